seg7_scan_decoder: RTL



---
 rtl/seg7_pkg.sv | 57 +++++
 rtl/seg7_scan_decoder_glyph_decode.sv | 54 +++++
 rtl/seg7_scan_decoder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : glyph constants, BCD codes and scan FSM states for seg7_scan_decoder
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

    // Only meaningful for a one-hot input
    function automatic logic [1:0] onehot_index(input logic [3:0] sel);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_decoder_glyph_decode.sv
// ============================================================================
// seg7_glyph_decode : combinational 7-segment pattern to BCD decoder
// Optional build macro SEG7_SCAN_HEX_EN accepts A..F and reports blanks separately.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       err
`ifdef SEG7_SCAN_HEX_EN
    ,
    output logic       blank
`endif
);

    always_comb begin
        bcd = BCD_ERR;
        err = 1'b1;
`ifdef SEG7_SCAN_HEX_EN
        blank = 1'b0;
`endif
        case (pattern)
            SEG_0: begin bcd = 4'h0; err = 1'b0; end
            SEG_1: begin bcd = 4'h1; err = 1'b0; end
            SEG_2: begin bcd = 4'h2; err = 1'b0; end
            SEG_3: begin bcd = 4'h3; err = 1'b0; end
            SEG_4: begin bcd = 4'h4; err = 1'b0; end
            SEG_5: begin bcd = 4'h5; err = 1'b0; end
            SEG_6: begin bcd = 4'h6; err = 1'b0; end
            SEG_7: begin bcd = 4'h7; err = 1'b0; end
            SEG_8: begin bcd = 4'h8; err = 1'b0; end
            SEG_9: begin bcd = 4'h9; err = 1'b0; end
`ifdef SEG7_SCAN_HEX_EN
            SEG_A: begin bcd = 4'hA; err = 1'b0; end
            SEG_B: begin bcd = 4'hB; err = 1'b0; end
            SEG_C: begin bcd = 4'hC; err = 1'b0; end
            SEG_D: begin bcd = 4'hD; err = 1'b0; end
            SEG_E: begin bcd = 4'hE; err = 1'b0; end
            SEG_F: begin bcd = 4'hF; err = 1'b0; end
            SEG_BLANK: begin bcd = 4'h0; err = 1'b0; blank = 1'b1; end
`else
            SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// seg7_scan_decoder : reconstructs a 4-digit frame from a multiplexed 7-seg scan
// Optional build macro SEG7_SCAN_HEX_EN adds hex glyphs and the blank_mask port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  dig_sel,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        glyph_err,
    output logic        sel_err,
    output logic        stale
`ifdef SEG7_SCAN_HEX_EN
    ,
    output logic [3:0]  blank_mask
`endif
);

    localparam logic       ACT_LOW  = (ACTIVE_LOW != 0);
    localparam logic [7:0] STABLE_V = 8'(STABLE_CYCLES);
    localparam int         IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_CYCLES);

    // Synchronizers reset to the inactive pin level so reset looks like an idle scan
    logic [3:0] sel_s1, sel_s2;
    logic [6:0] seg_s1, seg_s2;
    logic       dp_s1, dp_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_s1 <= {4{ACT_LOW}};
            sel_s2 <= {4{ACT_LOW}};
            seg_s1 <= {7{ACT_LOW}};
            seg_s2 <= {7{ACT_LOW}};
            dp_s1  <= ACT_LOW;
            dp_s2  <= ACT_LOW;
        end else begin
            sel_s1 <= dig_sel;
            sel_s2 <= sel_s1;
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
            dp_s1  <= dp;
            dp_s2  <= dp_s1;
        end
    end

    logic [3:0] sel;
    logic [7:0] sample;
    logic       onehot;
    logic       multi;
    logic [1:0] idx;

    assign sel    = sel_s2 ^ {4{ACT_LOW}};
    assign sample = {seg_s2 ^ {7{ACT_LOW}}, dp_s2 ^ ACT_LOW};
    assign onehot = $onehot(sel);
    assign multi  = (sel != 4'h0) && !onehot;
    assign idx    = onehot_index(sel);

    logic [3:0] bcd;
    logic       bcd_err;
`ifdef SEG7_SCAN_HEX_EN
    logic       bcd_blank;
`endif

    seg7_glyph_decode u_decode (
        .pattern (sample[7:1]),
        .bcd     (bcd),
        .err     (bcd_err)
`ifdef SEG7_SCAN_HEX_EN
        ,
        .blank   (bcd_blank)
`endif
    );

    scan_state_t state;
    logic [1:0]  cur_idx;
    logic [7:0]  cur_pat;
    logic [7:0]  stable_cnt;
    logic        start_new;
    logic        settle_hit;
    logic        capture;

    always_comb begin
        start_new  = onehot && (state == ST_IDLE || idx != cur_idx);
        settle_hit = onehot && (state == ST_SETTLE) && (idx == cur_idx) && (sample == cur_pat);
        capture    = (start_new && STABLE_CYCLES == 1) ||
                     (settle_hit && (stable_cnt + 8'd1) == STABLE_V);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cur_idx    <= 2'd0;
            cur_pat    <= 8'h00;
            stable_cnt <= 8'h00;
        end else if (!onehot) begin
            state      <= ST_IDLE;
        end else if (start_new) begin
            cur_idx    <= idx;
            cur_pat    <= sample;
            stable_cnt <= 8'd1;
            state      <= (STABLE_CYCLES == 1) ? ST_HOLD : ST_SETTLE;
        end else if (state == ST_SETTLE) begin
            if (sample != cur_pat) begin
                cur_pat    <= sample;
                stable_cnt <= 8'd1;
            end else begin
                stable_cnt <= stable_cnt + 8'd1;
                if (capture) state <= ST_HOLD;
            end
        end
    end

    logic [3:0]  mask;
    logic        frame_err;
    logic [19:0] shadow;

    // A capture in the frame-completion cycle lands after the mask clear and survives it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits        <= 16'hFFFF;
            dps           <= 4'h0;
            mask          <= 4'h0;
            frame_err     <= 1'b0;
            shadow        <= {16'hFFFF, 4'h0};
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            glyph_err     <= 1'b0;
`ifdef SEG7_SCAN_HEX_EN
            blank_mask    <= 4'h0;
`endif
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            if (mask == 4'hF) begin
                frame_valid   <= 1'b1;
                frame_changed <= ({digits, dps} != shadow);
                shadow        <= {digits, dps};
                mask          <= 4'h0;
                frame_err     <= 1'b0;
                if (!frame_err) glyph_err <= 1'b0;
            end
            if (capture) begin
                digits[{idx, 2'b00} +: 4] <= bcd;
                dps[idx]                  <= sample[0];
                mask[idx]                 <= 1'b1;
`ifdef SEG7_SCAN_HEX_EN
                blank_mask[idx]           <= bcd_blank;
`endif
                if (bcd_err) begin
                    glyph_err <= 1'b1;
                    frame_err <= 1'b1;
                end
            end
        end
    end

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err  <= 1'b0;
            idle_cnt <= '0;
            stale    <= 1'b0;
        end else begin
            sel_err <= multi;
            if (onehot) begin
                idle_cnt <= '0;
                stale    <= 1'b0;
            end else if (idle_cnt != TIMEOUT_V) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                stale    <= ((idle_cnt + IDLE_W'(1)) == TIMEOUT_V);
            end
        end
    end

endmodule

`default_nettype wire
